// File: rtl/knight_rider_scanner_pkg.sv
// Shared definitions for the knight-rider LED scanner: default sizes and the
// scan-mode encoding used on the mode input.
package knight_rider_scanner_pkg;

  localparam int DEF_CNT_W = 32;
  localparam int DEF_N_LED = 8;
  localparam int DEF_POS_W = 3;

  typedef enum logic {
    MODE_BOUNCE = 1'b0,
    MODE_WRAP   = 1'b1
  } mode_e;

endpackage

// File: rtl/knight_rider_scanner_if.sv
// Control/status bundle between a scanner and whatever drives it: the controller
// owns run/period/mode, the scanner owns the LED pattern and step pulse.
interface knight_rider_scanner_if
  import knight_rider_scanner_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int N_LED = DEF_N_LED,
  parameter int POS_W = DEF_POS_W
);

  logic             en;
  logic [CNT_W-1:0] period;
  logic             mode;
  logic [N_LED-1:0] led;
  logic [POS_W-1:0] pos;
  logic             dir;
  logic             tick;

  modport master (
    output en, period, mode,
    input  led, pos, dir, tick
  );

  modport slave (
    input  en, period, mode,
    output led, pos, dir, tick
  );

endinterface

// File: rtl/knight_rider_scanner_rate_tick.sv
// Programmable rate generator: counts enabled cycles and expires once every
// period+1 of them. Reusable by any block needing a run-time adjustable tick.
module rate_tick #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  output logic             expire,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  // ">=" rather than "==" so a period lowered below the running count expires
  // on the next enabled edge instead of waiting for the counter to wrap.
  assign expire = en && (cnt >= period);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= expire;
      if (en) begin
        cnt <= expire ? '0 : cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/knight_rider_scanner.sv
// Knight-rider LED scanner: a rate_tick prescaler steps a one-hot position that
// either bounces between the end LEDs or wraps around, with a registered decode.
module knight_rider_scanner
  import knight_rider_scanner_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int N_LED = DEF_N_LED,
  parameter int POS_W = DEF_POS_W
) (
  input  logic                 clk,
  input  logic                 rst,
  knight_rider_scanner_if.slave bus
);

  // Two-state direction FSM; the state register is the dir output itself.
  localparam logic [0:0] UP   = 1'b0;
  localparam logic [0:0] DOWN = 1'b1;

  localparam logic [POS_W-1:0] LAST = POS_W'(N_LED - 1);

  logic             step;
  logic             tick;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_nxt;
  logic [0:0]       dir_q;
  logic [0:0]       dir_nxt;
  logic [N_LED-1:0] led_q;

  rate_tick #(
    .CNT_W (CNT_W)
  ) u_rate_tick (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.en),
    .period (bus.period),
    .expire (step),
    .tick   (tick)
  );

  // NOTE: next-state signals get their hold value first, so every path through
  // the block assigns them and no latch is inferred.
  always_comb begin
    pos_nxt = pos_q;
    dir_nxt = dir_q;
    // A single LED has nowhere to go: position and direction stay put.
    if (step && (N_LED > 1)) begin
      if (bus.mode == MODE_WRAP) begin
        if (dir_q == UP) begin
          pos_nxt = (pos_q == LAST) ? '0 : pos_q + 1'b1;
        end else begin
          pos_nxt = (pos_q == '0) ? LAST : pos_q - 1'b1;
        end
      end else if (dir_q == UP) begin
        if (pos_q == LAST) begin
          dir_nxt = DOWN;
          pos_nxt = pos_q - 1'b1;
        end else begin
          pos_nxt = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          dir_nxt = UP;
          pos_nxt = pos_q + 1'b1;
        end else begin
          pos_nxt = pos_q - 1'b1;
        end
      end
    end
  end

  // Decoding pos_nxt keeps led aligned with pos on the very same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q <= '0;
      dir_q <= UP;
      led_q <= N_LED'(1);
    end else begin
      pos_q <= pos_nxt;
      dir_q <= dir_nxt;
      led_q <= N_LED'(1) << pos_nxt;
    end
  end

  assign bus.led  = led_q;
  assign bus.pos  = pos_q;
  assign bus.dir  = dir_q;
  assign bus.tick = tick;

endmodule
